// File: rtl/signal_sync_filter_pkg.sv
// ============================================================================
// Package : signal_sync_pkg
// Brief   : Shared constants and helpers for the signal_sync_filter block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package signal_sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;

  // Debounce counter width: max(1, clog2(n)).
  function automatic int sync_cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/signal_sync_filter_chan.sv
// ============================================================================
// Module : sync_filter_chan
// Brief  : One channel: STAGES-deep synchronizer, debounce counter, strobes.
//          Edge strobes present when SIGNAL_SYNC_FILTER_EDGE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_filter_chan
  import signal_sync_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic clkB,
  input  logic rstB,
  input  logic inA,
  output logic outB,
  output logic changeB
`ifdef SIGNAL_SYNC_FILTER_EDGE_EN
  ,
  output logic riseB,
  output logic fallB
`endif
);

  localparam int             CW        = sync_cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0]  C_CNT_MAX = CW'(FILT_CYCLES - 1);

  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_out;
  logic              r_change;
  logic              w_syncd;
  logic              w_fire;

  assign w_syncd = r_sync[STAGES-1];
  assign w_fire  = (w_syncd != r_out) && (r_cnt == C_CNT_MAX);

  always_ff @(posedge clkB or posedge rstB) begin
    if (rstB) begin
      r_sync <= {STAGES{RESET_BIT}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], inA};
    end
  end

  // Counter tracks consecutive cycles the synced level disagrees with outB;
  // any agreement clears it so separate glitches never accumulate.
  always_ff @(posedge clkB or posedge rstB) begin
    if (rstB) begin
      r_cnt    <= '0;
      r_out    <= RESET_BIT;
      r_change <= 1'b0;
    end else begin
      r_change <= 1'b0;
      if (w_syncd == r_out) begin
        r_cnt <= '0;
      end else if (w_fire) begin
        r_out    <= w_syncd;
        r_cnt    <= '0;
        r_change <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign outB    = r_out;
  assign changeB = r_change;

`ifdef SIGNAL_SYNC_FILTER_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clkB or posedge rstB) begin
    if (rstB) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_fire &  w_syncd;
      r_fall <= w_fire & ~w_syncd;
    end
  end

  assign riseB = r_rise;
  assign fallB = r_fall;
`endif

endmodule

`default_nettype wire

// File: rtl/signal_sync_filter.sv
// ============================================================================
// Module : signal_sync_filter
// Brief  : WIDTH-channel level synchronizer with per-bit glitch filter.
//          Define SIGNAL_SYNC_FILTER_EDGE_EN to add riseB/fallB strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module signal_sync_filter
  import signal_sync_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clkB,
  input  logic             rstB,
  input  logic [WIDTH-1:0] inA,
  output logic [WIDTH-1:0] outB,
  output logic [WIDTH-1:0] changeB
`ifdef SIGNAL_SYNC_FILTER_EDGE_EN
  ,
  output logic [WIDTH-1:0] riseB,
  output logic [WIDTH-1:0] fallB
`endif
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_chk_stages
    $error("signal_sync_filter: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end
  if (FILT_CYCLES < 1) begin : g_chk_filt
    $error("signal_sync_filter: FILT_CYCLES must be >= 1");
  end
  if (WIDTH < 1) begin : g_chk_width
    $error("signal_sync_filter: WIDTH must be >= 1");
  end

  // Channels are independent; no cross-bit coherency.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RESET_BIT   (RESET_VAL[i])
    ) u_chan (
      .clkB    (clkB),
      .rstB    (rstB),
      .inA     (inA[i]),
      .outB    (outB[i]),
      .changeB (changeB[i])
`ifdef SIGNAL_SYNC_FILTER_EDGE_EN
      ,
      .riseB   (riseB[i]),
      .fallB   (fallB[i])
`endif
    );
  end

endmodule

`default_nettype wire
